// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: fetches one opcode byte plus a 5- or 8-byte little-endian
// operand from byte-wide instruction memory. The assembled instruction is held
// for the decoder until the execute stage reports completion. The block owns
// the program counter.
//
// Memory handshake: a byte moves on every cycle where mem_req && mem_ack.
// mem_rdata is sampled in that same cycle. mem_req stays asserted, and
// mem_addr stays equal to pc, until the memory accepts the request.
module inst_fetch_seq #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  opc,
    output logic [63:0] opl,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        jmp,
    input  logic [63:0] jmp_addr,
    output logic [63:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPC   = 2'd1,
        S_OPL   = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [7:0]  opc_q, opc_d;
    logic [63:0] opl_q, opl_d;
    logic [2:0]  cnt_q, cnt_d;
    // Set when the current opcode selects the 5-byte operand form.
    logic        short_q, short_d;
    logic        xfer;
    logic [2:0]  last_cnt;

    // Request and valid are decoded purely from the registered state.
    assign mem_req    = (state_q == S_OPC) || (state_q == S_OPL);
    assign inst_valid = (state_q == S_ISSUE);
    assign xfer       = mem_req && mem_ack;
    assign last_cnt   = short_q ? 3'd4 : 3'd7;
    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign opc        = opc_q;
    assign opl        = opl_q;

    // State register and datapath registers; reset abandons any fetch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            opc_q   <= 8'h00;
            opl_q   <= 64'h0;
            cnt_q   <= 3'd0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            opl_q   <= opl_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
        end
    end

    // Next-state and datapath update. exec_done/jmp only matter in S_ISSUE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        opl_d   = opl_q;
        cnt_d   = cnt_q;
        short_d = short_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_OPC;
            end
            S_OPC: begin
                if (xfer) begin
                    opc_d   = mem_rdata;
                    opl_d   = 64'h0;
                    cnt_d   = 3'd0;
                    short_d = mem_rdata[0];
                    pc_d    = pc_q + 64'd1;
                    state_d = S_OPL;
                end
            end
            S_OPL: begin
                if (xfer) begin
                    opl_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                    cnt_d = cnt_q + 3'd1;
                    pc_d  = pc_q + 64'd1;
                    if (cnt_q == last_cnt) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (exec_done) begin
                    state_d = S_OPC;
                    if (jmp) begin
                        pc_d = jmp_addr;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
